// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module : stopwatch_pkg
// Brief  : Shared state encoding and BCD constants for the stopwatch path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam int          DIGITS     = 4;
    localparam logic [15:0] CLEAR_WORD = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
// ============================================================================
// Module : stopwatch_ctrl_if
// Brief  : Button/tick inputs and count/display outputs of the stopwatch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic                  tick;
    logic                  btn_ss;
    logic                  btn_lr;
    logic [4*DIGITS-1:0]   count_data;
    logic [4*DIGITS-1:0]   disp_data;
    logic                  run;
    logic                  lap_frozen;
    logic                  ovf;

    modport master (
        output tick, btn_ss, btn_lr,
        input  count_data, disp_data, run, lap_frozen, ovf
    );

    modport slave (
        input  tick, btn_ss, btn_lr,
        output count_data, disp_data, run, lap_frozen, ovf
    );

endinterface

`default_nettype wire

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// ============================================================================
// Module : bcd_digit
// Brief  : Mod-10 BCD digit with increment, clear and carry-out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import stopwatch_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       clr,
    input  wire logic       inc,
    output logic      [3:0] value,
    output logic            carry
);

    assign carry = inc && (value == BCD_MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= 4'd0;
        end else if (inc) begin
            value <= (value == BCD_MAX) ? 4'd0 : value + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module : stopwatch_ctrl
// Brief  : Run/lap/stop/clear sequencer owning the SS.cc BCD time count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter bit HOLD_BTN_AT_RST = 1'b1
)(
    input  wire logic          clk,
    input  wire logic          rst,
    stopwatch_ctrl_if.slave    bus
);

    state_t              state;
    state_t              next_state;
    logic                ss_q;
    logic                lr_q;
    logic                ss_e;
    logic                lr_e;
    logic                lap_load;
    logic                clear;
    logic                count_en;
    logic [DIGITS:0]     inc_chain;
    logic [4*DIGITS-1:0] count_word;
    logic [4*DIGITS-1:0] lap_reg;
    logic                ovf;

    // Loading the live level during reset keeps a held button from firing.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q <= HOLD_BTN_AT_RST ? bus.btn_ss : 1'b0;
            lr_q <= HOLD_BTN_AT_RST ? bus.btn_lr : 1'b0;
        end else begin
            ss_q <= bus.btn_ss;
            lr_q <= bus.btn_lr;
        end
    end

    assign ss_e = bus.btn_ss & ~ss_q;
    assign lr_e = bus.btn_lr & ~lr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ss_e is tested first everywhere so it wins over a simultaneous lr_e.
    always_comb begin
        next_state = state;
        lap_load   = 1'b0;
        clear      = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_e) next_state = RUN;
            end
            RUN: begin
                if (ss_e) begin
                    next_state = STOP;
                end else if (lr_e) begin
                    next_state = LAP;
                    lap_load   = 1'b1;
                end
            end
            LAP: begin
                if (ss_e) begin
                    next_state = STOP;
                end else if (lr_e) begin
                    next_state = RUN;
                end
            end
            STOP: begin
                if (ss_e) begin
                    next_state = RUN;
                end else if (lr_e) begin
                    next_state = IDLE;
                    clear      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Counting follows the pre-transition state, so a tick on a stop edge counts.
    assign count_en     = bus.tick && ((state == RUN) || (state == LAP));
    assign inc_chain[0] = count_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .inc   (inc_chain[i]),
            .value (count_word[4*i +: 4]),
            .carry (inc_chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lap_reg <= CLEAR_WORD;
            ovf     <= 1'b0;
        end else begin
            if (lap_load) lap_reg <= count_word;
            if (inc_chain[DIGITS]) ovf <= 1'b1;
        end
    end

    assign bus.count_data = count_word;
    assign bus.disp_data  = (state == LAP) ? lap_reg : count_word;
    assign bus.run        = (state == RUN) || (state == LAP);
    assign bus.lap_frozen = (state == LAP);
    assign bus.ovf        = ovf;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module : tb_stopwatch_ctrl
// Brief  : Directed self-checking bench for stopwatch_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(
        .DIGITS          (4),
        .HOLD_BTN_AT_RST (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        sw.tick = 1'b1;
        step(n);
        sw.tick = 1'b0;
    endtask

    task automatic press_ss();
        sw.btn_ss = 1'b1;
        step(1);
        sw.btn_ss = 1'b0;
        step(1);
    endtask

    task automatic press_lr();
        sw.btn_lr = 1'b1;
        step(1);
        sw.btn_lr = 1'b0;
        step(1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        sw.tick   = 1'b0;
        sw.btn_ss = 1'b0;
        sw.btn_lr = 1'b0;
        step(3);
        chk("rst_count", sw.count_data, 16'h0000);
        chk("rst_disp",  sw.disp_data,  16'h0000);
        chk("rst_flags", {13'd0, sw.run, sw.lap_frozen, sw.ovf}, 16'h0000);
        rst = 1'b0;
        step(1);

        ticks(5);
        chk("idle_no_count", sw.count_data, 16'h0000);

        press_ss();
        chk("run_after_ss", {15'd0, sw.run}, 16'h0001);
        ticks(123);
        chk("count_123", sw.count_data, 16'h0123);
        chk("disp_123",  sw.disp_data,  16'h0123);
        press_ss();
        chk("stop_run", {15'd0, sw.run}, 16'h0000);
        ticks(10);
        chk("stop_holds", sw.count_data, 16'h0123);

        press_lr();
        chk("clear_count", sw.count_data, 16'h0000);
        chk("clear_idle",  {14'd0, sw.run, sw.lap_frozen}, 16'h0000);

        press_ss();
        ticks(500);
        chk("count_500", sw.count_data, 16'h0500);
        press_lr();
        chk("lap_frozen", {15'd0, sw.lap_frozen}, 16'h0001);
        chk("lap_disp",   sw.disp_data, 16'h0500);
        ticks(250);
        chk("lap_live",   sw.count_data, 16'h0750);
        chk("lap_held",   sw.disp_data,  16'h0500);
        press_lr();
        chk("lap_release", sw.disp_data, 16'h0750);
        chk("lap_rel_flag", {14'd0, sw.run, sw.lap_frozen}, 16'h0002);

        // Both buttons and a tick on one edge: stop wins, tick still counts.
        sw.btn_ss = 1'b1;
        sw.btn_lr = 1'b1;
        sw.tick   = 1'b1;
        step(1);
        sw.btn_ss = 1'b0;
        sw.btn_lr = 1'b0;
        sw.tick   = 1'b0;
        chk("simul_stop",  {14'd0, sw.run, sw.lap_frozen}, 16'h0000);
        chk("simul_count", sw.count_data, 16'h0751);
        step(1);
        chk("simul_disp",  sw.disp_data, 16'h0751);

        press_lr();
        press_lr();
        chk("idle_lr_noop", {sw.count_data[13:0], sw.run, sw.ovf}, 16'h0000);

        press_ss();
        ticks(9998);
        chk("pre_wrap", sw.count_data, 16'h9998);
        chk("pre_wrap_ovf", {15'd0, sw.ovf}, 16'h0000);
        ticks(2);
        chk("wrap_count", sw.count_data, 16'h0000);
        chk("wrap_flags", {14'd0, sw.run, sw.ovf}, 16'h0003);
        ticks(1);
        chk("post_wrap", sw.count_data, 16'h0001);
        press_ss();
        chk("ovf_sticky", {15'd0, sw.ovf}, 16'h0001);
        press_lr();
        chk("ovf_clear", {sw.count_data[14:0], sw.ovf}, 16'h0000);

        // Button held through reset must not start the watch.
        sw.btn_ss = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        chk("hold_idle", {15'd0, sw.run}, 16'h0000);
        sw.btn_ss = 1'b0;
        step(1);
        press_ss();
        chk("hold_then_run", {15'd0, sw.run}, 16'h0001);
        ticks(42);
        chk("hold_count", sw.count_data, 16'h0042);

        rst     = 1'b1;
        sw.tick = 1'b1;
        step(1);
        sw.tick = 1'b0;
        chk("midrun_rst_count", sw.count_data, 16'h0000);
        chk("midrun_rst_run",   {15'd0, sw.run}, 16'h0000);
        rst = 1'b0;
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
